// File: rtl/jt900h_muldiv.sv
// jt900h_muldiv: iterative radix-2 signed/unsigned multiply/divide at width W or W/2.
// Define JT900H_MULDIV_EARLY_EN to send unsigned divide overflow straight to FIX.
`timescale 1ns/1ps
module jt900h_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           start,
  input  logic           op,
  input  logic           sign,
  input  logic           len,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   rslt_lo,
  output logic [W-1:0]   rslt_hi,
  output logic           v
);
  localparam int H = W / 2;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state, state_nx;

  logic           op_r, sign_r, len_r, sa_r, sb_r, ovf_r;
  logic [2*W-1:0] a_r, acc, mc;
  logic [W-1:0]   rem, quo, bmag, mp;
  logic [5:0]     cnt;

  function automatic logic [W-1:0] fit(input logic l, input logic [W-1:0] x);
    fit = l ? x : {{H{1'b0}}, x[H-1:0]};
  endfunction

  // Operand magnitudes and signs, computed from the live inputs for latching in IDLE
  logic [2*W-1:0] dval, dmag_in;
  logic [W-1:0]   mval, mmag_in, bval, bmag_in, dhi_in, dlo_in;
  logic           d_sgn, m_sgn, b_sgn, ovf_in;
  always_comb begin
    dval    = len ? a : {{W{1'b0}}, a[W-1:0]};
    d_sgn   = sign & (len ? a[2*W-1] : a[W-1]);
    dmag_in = d_sgn ? -dval : dval;
    if (!len) dmag_in[2*W-1:W] = '0;
    mval    = fit(len, a[W-1:0]);
    m_sgn   = sign & (len ? a[W-1] : a[H-1]);
    mmag_in = fit(len, m_sgn ? -mval : mval);
    bval    = fit(len, b);
    b_sgn   = sign & (len ? b[W-1] : b[H-1]);
    bmag_in = fit(len, b_sgn ? -bval : bval);
    dhi_in  = len ? dmag_in[2*W-1:W] : {{H{1'b0}}, dmag_in[W-1:H]};
    dlo_in  = fit(len, dmag_in[W-1:0]);
    ovf_in  = dhi_in >= bmag_in;
  end

  // Restoring divide step; the quotient register doubles as the low dividend shifter
  logic         qmsb, ge;
  logic [W:0]   t;
  logic [W-1:0] rem_nx;
  always_comb begin
    qmsb   = len_r ? quo[W-1] : quo[H-1];
    t      = {rem, qmsb};
    ge     = t >= {1'b0, bmag};
    rem_nx = ge ? W'(t - {1'b0, bmag}) : t[W-1:0];
  end

  // Sign fix-up and overflow selection
  logic [W-1:0]   qmag, rmag, ahi, alo, fix_lo, fix_hi;
  logic [2*W-1:0] prod;
  logic [W:0]     lim;
  logic           neg, fix_v;
  always_comb begin
    neg    = sa_r ^ sb_r;
    qmag   = fit(len_r, quo);
    rmag   = fit(len_r, rem);
    lim    = (W+1)'(1) << (len_r ? W-1 : H-1);
    ahi    = len_r ? a_r[2*W-1:W] : {{H{1'b0}}, a_r[W-1:H]};
    alo    = fit(len_r, a_r[W-1:0]);
    prod   = neg ? -acc : acc;
    fix_v  = 1'b0;
    fix_lo = '0;
    fix_hi = '0;
    if (op_r) begin
      fix_lo = fit(len_r, prod[W-1:0]);
      fix_hi = len_r ? prod[2*W-1:W] : {{H{1'b0}}, prod[W-1:H]};
    end else begin
      fix_v  = ovf_r | (sign_r & (neg ? ({1'b0, qmag} > lim) : ({1'b0, qmag} >= lim)));
      fix_lo = fit(len_r, neg ? -qmag : qmag);
      fix_hi = fit(len_r, sa_r ? -rmag : rmag);
      if (fix_v) begin
        fix_lo = alo;
        fix_hi = ahi;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
`ifdef JT900H_MULDIV_EARLY_EN
        state_nx = (!op && !sign && ovf_in) ? FIX : ITER;
`else
        state_nx = ITER;
`endif
      end
      ITER:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      v       <= 1'b0;
      rslt_lo <= '0;
      rslt_hi <= '0;
      op_r    <= 1'b0;
      sign_r  <= 1'b0;
      len_r   <= 1'b0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      ovf_r   <= 1'b0;
      a_r     <= '0;
      acc     <= '0;
      mc      <= '0;
      rem     <= '0;
      quo     <= '0;
      bmag    <= '0;
      mp      <= '0;
      cnt     <= '0;
    end else if (cen) begin
      state <= state_nx;
      done  <= (state == FIX);
      case (state)
        IDLE: if (start) begin
          op_r   <= op;
          sign_r <= sign;
          len_r  <= len;
          a_r    <= a;
          sa_r   <= op ? m_sgn : d_sgn;
          sb_r   <= b_sgn;
          ovf_r  <= ovf_in;
          rem    <= dhi_in;
          quo    <= dlo_in;
          bmag   <= bmag_in;
          acc    <= '0;
          mc     <= {{W{1'b0}}, mmag_in};
          mp     <= bmag_in;
          cnt    <= len ? 6'(W-1) : 6'(H-1);
          v      <= 1'b0;
        end
        ITER: begin
          cnt <= cnt - 6'd1;
          if (op_r) begin
            if (mp[0]) acc <= acc + mc;
            mc <= mc << 1;
            mp <= mp >> 1;
          end else begin
            rem <= rem_nx;
            quo <= {quo[W-2:0], ge};
          end
        end
        FIX: begin
          rslt_lo <= fix_lo;
          rslt_hi <= fix_hi;
          v       <= fix_v;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Self-checking bench for jt900h_muldiv (W=16): directed vectors, random ops vs. arithmetic model, control cases.
`timescale 1ns/1ps
module tb_jt900h_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, start = 1'b0;
  logic        op = 1'b0, sign = 1'b0, len = 1'b1;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, v;
  logic [15:0] rslt_lo, rslt_hi;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  jt900h_muldiv #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .op(op), .sign(sign),
    .len(len), .a(a), .b(b), .busy(busy), .done(done),
    .rslt_lo(rslt_lo), .rslt_hi(rslt_hi), .v(v)
  );

  function automatic void model(input bit op_i, input bit sign_i, input bit len_i,
                                input logic [31:0] a_i, input logic [15:0] b_i,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output bit v_o, output int lat);
    int n;
    longint da, db, q, r, p, m, half;
    n = len_i ? 16 : 8;
    m = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    lat = n + 2; v_o = 1'b0; lo = '0; hi = '0;
    if (op_i) begin
      if (len_i) begin
        if (sign_i) begin da = longint'($signed(a_i[15:0])); db = longint'($signed(b_i)); end
        else begin da = longint'(a_i[15:0]); db = longint'(b_i); end
      end else begin
        if (sign_i) begin da = longint'($signed(a_i[7:0])); db = longint'($signed(b_i[7:0])); end
        else begin da = longint'(a_i[7:0]); db = longint'(b_i[7:0]); end
      end
      p  = da * db;
      lo = 16'(p & m);
      hi = 16'((p >> n) & m);
    end else begin
      if (len_i) begin
        if (sign_i) begin da = longint'($signed(a_i)); db = longint'($signed(b_i)); end
        else begin da = longint'(a_i); db = longint'(b_i); end
      end else begin
        if (sign_i) begin da = longint'($signed(a_i[15:0])); db = longint'($signed(b_i[7:0])); end
        else begin da = longint'(a_i[15:0]); db = longint'(b_i[7:0]); end
      end
      if (db == 0) v_o = 1'b1;
      else begin
        q = da / db;
        r = da % db;
        if (sign_i) v_o = (q > half - 1) || (q < -half);
        else        v_o = q > m;
        lo = 16'(q & m);
        hi = 16'(r & m);
      end
`ifdef JT900H_MULDIV_EARLY_EN
      if (!sign_i && v_o) lat = 2;
`endif
      if (v_o) begin
        lo = 16'(longint'(a_i) & m);
        hi = 16'((longint'(a_i) >> n) & m);
      end
    end
  endfunction

  // Issue one operation and count cen-high edges until done is first seen
  task automatic do_op(input bit op_i, input bit sign_i, input bit len_i,
                       input logic [31:0] a_i, input logic [15:0] b_i,
                       input bit rnd, input bit hold, output int lat);
    @(negedge clk);
    op = op_i; sign = sign_i; len = len_i; a = a_i; b = b_i; start = 1'b1; cen = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      cen = rnd ? 1'($urandom % 2) : 1'b1;
      @(posedge clk);
      if (cen) lat++;
      @(negedge clk);
    end
    cen = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", v); end
    checks++; if (rslt_lo !== 16'h0) begin errors++; $display("FAIL reset_lo: got %h want 0000", rslt_lo); end
    checks++; if (rslt_hi !== 16'h0) begin errors++; $display("FAIL reset_hi: got %h want 0000", rslt_hi); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    bit          t_op[5]   = '{0, 0, 0, 1, 0};
    bit          t_sg[5]   = '{0, 1, 0, 1, 1};
    bit          t_ln[5]   = '{1, 0, 1, 1, 0};
    logic [31:0] t_a[5]    = '{32'h0000_1234, 32'h0000_FF9C, 32'h0000_1234, 32'h0000_FFFE, 32'h0000_8000};
    logic [15:0] t_b[5]    = '{16'h0010, 16'h0007, 16'h0000, 16'h0003, 16'h00FF};
    logic [15:0] t_lo[5]   = '{16'h0123, 16'h00F2, 16'h1234, 16'hFFFA, 16'h0000};
    logic [15:0] t_hi[5]   = '{16'h0004, 16'h00FE, 16'h0000, 16'hFFFF, 16'h0080};
    bit          t_v[5]    = '{0, 0, 1, 0, 1};
`ifdef JT900H_MULDIV_EARLY_EN
    int          t_lat[5]  = '{18, 10, 2, 18, 10};
`else
    int          t_lat[5]  = '{18, 10, 18, 18, 10};
`endif
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_sg[i], t_ln[i], t_a[i], t_b[i], 1'b0, 1'b0, lat);
      checks++; if (lat !== t_lat[i]) begin errors++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, t_lat[i]); end
      checks++; if (rslt_lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, rslt_lo, t_lo[i]); end
      checks++; if (rslt_hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, rslt_hi, t_hi[i]); end
      checks++; if (v !== t_v[i]) begin errors++; $display("FAIL dir%0d_v: got %b want %b", i, v, t_v[i]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); end
      @(posedge clk); @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    bit op_i, sg_i, ln_i, ev;
    logic [31:0] a_i;
    logic [15:0] b_i, elo, ehi;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      op_i = 1'($urandom % 2); sg_i = 1'($urandom % 2); ln_i = 1'($urandom % 2);
      a_i = $urandom; b_i = 16'($urandom);
      if (!op_i && ($urandom % 2 == 1)) a_i = a_i >> $urandom_range(8, 24);
      if ($urandom % 16 == 0) b_i = '0;
      model(op_i, sg_i, ln_i, a_i, b_i, elo, ehi, ev, elat);
      do_op(op_i, sg_i, ln_i, a_i, b_i, 1'b0, 1'b0, lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, elat); end
      checks++; if (rslt_lo !== elo) begin errors++; $display("FAIL rnd%0d_lo: op=%b s=%b l=%b a=%h b=%h got %h want %h", i, op_i, sg_i, ln_i, a_i, b_i, rslt_lo, elo); end
      checks++; if (rslt_hi !== ehi) begin errors++; $display("FAIL rnd%0d_hi: op=%b s=%b l=%b a=%h b=%h got %h want %h", i, op_i, sg_i, ln_i, a_i, b_i, rslt_hi, ehi); end
      checks++; if (v !== ev) begin errors++; $display("FAIL rnd%0d_v: op=%b s=%b l=%b a=%h b=%h got %b want %b", i, op_i, sg_i, ln_i, a_i, b_i, v, ev); end
    end
  endtask

  task automatic test_busy_restart();
    int lat;
    @(negedge clk);
    op = 1'b0; sign = 1'b0; len = 1'b1; a = 32'h0000_1234; b = 16'h0010; start = 1'b1; cen = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      if (i == 3) begin op = 1'b1; sign = 1'b1; a = $urandom; b = 16'($urandom); start = 1'b1; end
      else if (i == 5) start = 1'b0;
      @(posedge clk); lat++; @(negedge clk);
    end
    start = 1'b0;
    checks++; if (lat !== 18) begin errors++; $display("FAIL restart_lat: got %0d want 18", lat); end
    checks++; if (rslt_lo !== 16'h0123) begin errors++; $display("FAIL restart_lo: got %h want 0123", rslt_lo); end
    checks++; if (rslt_hi !== 16'h0004) begin errors++; $display("FAIL restart_hi: got %h want 0004", rslt_hi); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL restart_v: got %b want 0", v); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = 1'b0; sign = 1'b0; len = 1'b1; a = 32'h0000_1234; b = 16'h0010; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (rslt_lo !== 16'h0) begin errors++; $display("FAIL midrst_lo: got %h want 0000", rslt_lo); end
    checks++; if (rslt_hi !== 16'h0) begin errors++; $display("FAIL midrst_hi: got %h want 0000", rslt_hi); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL midrst_v: got %b want 0", v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cen_random();
    int lat;
    do_op(1'b0, 1'b0, 1'b1, 32'h0000_1234, 16'h0010, 1'b1, 1'b0, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL cen_lat: got %0d want 18", lat); end
    checks++; if (rslt_lo !== 16'h0123) begin errors++; $display("FAIL cen_lo: got %h want 0123", rslt_lo); end
    checks++; if (rslt_hi !== 16'h0004) begin errors++; $display("FAIL cen_hi: got %h want 0004", rslt_hi); end
    cen = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cen_done_hold: got %b want 1", done); end
    cen = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cen_done_drop: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 1'b0, 1'b1, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_lat1: got %0d want 10", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done: got %b want 0", busy); end
    checks++; if (rslt_lo !== 16'h00F2) begin errors++; $display("FAIL b2b_lo1: got %h want 00f2", rslt_lo); end
    @(posedge clk);
    lat = 1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_lat2: got %0d want 10", lat); end
    checks++; if (rslt_lo !== 16'h00F2) begin errors++; $display("FAIL b2b_lo2: got %h want 00f2", rslt_lo); end
    checks++; if (rslt_hi !== 16'h00FE) begin errors++; $display("FAIL b2b_hi2: got %h want 00fe", rslt_hi); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_restart();
    test_reset_mid();
    test_cen_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
